// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared state encoding, default parameters and counter sizing for the PUF evaluator
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LAUNCH,
        ST_SETTLE,
        ST_SAMPLE,
        ST_RESP
    } puf_state_e;

    localparam int CH_W_DEF   = 16;
    localparam int N_CH_DEF   = 4;
    localparam int N_EVAL_DEF = 5;
    localparam int SETTLE_DEF = 4;

    // Bits needed to count 0..n inclusive.
    function automatic int vote_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// rtl/puf_vote_counter.sv - one channel's vote counter with majority and unanimity flags
// Flags reflect the count including the sample being added this cycle.
module puf_vote_counter
    import puf_pkg::*;
#(
    parameter int N_EVAL = N_EVAL_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    input  logic bit_i,
    output logic majority_o,
    output logic unanimous_o
);

    localparam int            CW   = vote_cnt_w(N_EVAL);
    localparam logic [CW-1:0] HALF = CW'(N_EVAL / 2);
    localparam logic [CW-1:0] FULL = CW'(N_EVAL);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && bit_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign majority_o  = (count_d > HALF);
    assign unanimous_o = (count_d == '0) || (count_d == FULL);

endmodule

// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - repeated clear/launch/settle/sample evaluation with majority-voted response
// Optional macro PUF_XOR_EN: rsp_xor carries the registered XOR of rsp_data.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int CH_W   = CH_W_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int N_EVAL = N_EVAL_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [CH_W-1:0] req_challenge,
    output logic [CH_W-1:0] puf_challenge,
    output logic            puf_clr,
    output logic            puf_launch,
    input  logic [N_CH-1:0] arb_bit,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N_CH-1:0] rsp_data,
    output logic [N_CH-1:0] rsp_stable,
    output logic            rsp_xor
);

    localparam int            EW          = vote_cnt_w(N_EVAL);
    localparam int            SW          = vote_cnt_w(SETTLE);
    localparam logic [EW-1:0] EVAL_LAST   = EW'(N_EVAL - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    if ((N_EVAL < 1) || ((N_EVAL % 2) == 0)) begin : g_bad_n_eval
        $error("puf_eval_ctrl: N_EVAL must be odd and >= 1");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("puf_eval_ctrl: SETTLE must be >= 1");
    end
    if (N_CH < 1) begin : g_bad_n_ch
        $error("puf_eval_ctrl: N_CH must be >= 1");
    end

    puf_state_e      state_q;
    logic            req_ready_q;
    logic [CH_W-1:0] chal_q;
    logic            clr_q;
    logic            launch_q;
    logic            rsp_valid_q;
    logic [N_CH-1:0] rsp_data_q;
    logic [N_CH-1:0] rsp_stable_q;
    logic [EW-1:0]   eval_q;
    logic [SW-1:0]   settle_q;

    logic            accept;
    logic            sample_en;
    logic            last_sample;
    logic [N_CH-1:0] maj;
    logic [N_CH-1:0] una;

    assign accept      = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign sample_en   = (state_q == ST_SAMPLE);
    assign last_sample = sample_en && (eval_q == EVAL_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        puf_vote_counter #(
            .N_EVAL (N_EVAL)
        ) u_vote (
            .clk_i       (CLK),
            .rst_ni      (RST_N),
            .clr_i       (accept),
            .inc_i       (sample_en),
            .bit_i       (arb_bit[i]),
            .majority_o  (maj[i]),
            .unanimous_o (una[i])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            chal_q       <= '0;
            clr_q        <= 1'b0;
            launch_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_stable_q <= '0;
            eval_q       <= '0;
            settle_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        chal_q      <= req_challenge;
                        eval_q      <= '0;
                        clr_q       <= 1'b1;
                        state_q     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    clr_q    <= 1'b0;
                    launch_q <= 1'b1;
                    state_q  <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    settle_q <= '0;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                ST_SAMPLE: begin
                    launch_q <= 1'b0;
                    if (eval_q == EVAL_LAST) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= maj;
                        rsp_stable_q <= una;
                        state_q      <= ST_RESP;
                    end else begin
                        eval_q  <= eval_q + EW'(1);
                        clr_q   <= 1'b1;
                        state_q <= ST_CLEAR;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PUF_XOR_EN
    logic rsp_xor_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_xor_q <= 1'b0;
        end else if (last_sample) begin
            rsp_xor_q <= ^maj;
        end
    end

    assign rsp_xor = rsp_xor_q;
`else
    assign rsp_xor = 1'b0;
`endif

    assign req_ready     = req_ready_q;
    assign puf_challenge = chal_q;
    assign puf_clr       = clr_q;
    assign puf_launch    = launch_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_stable    = rsp_stable_q;

endmodule
